// File: rtl/mux_sched_pkg.sv
// Shared definitions for the 16:1 mux-tree round-robin scheduler.
package mux_sched_pkg;

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 15->0.
module rr_pick
   import mux_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   rot;
   logic [SEL_W-1:0]   off;
   logic               found;

   always_comb begin
      // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
      req_dbl = {req, req};
      rot     = req_dbl[ptr +: N_REQ];
      off     = '0;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (rot[i] && !found) begin
            off   = SEL_W'(i);
            found = 1'b1;
         end
      end
      any = |req;
      idx = off + ptr;
   end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler driving the 16:1 mux-tree select, with a bounded burst per grant.
module mux16_rr_scheduler
   import mux_sched_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      req,
   input  logic             out_ready,
   output logic [3:0]       sel,
   output logic [15:0]      gnt,
   output logic             out_valid,
   output logic [7:0]       beat_cnt
);

   localparam logic [7:0] LAST_BEAT = 8'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [7:0]       beat_cnt_q, beat_cnt_d;

   logic [SEL_W-1:0] pick_ptr;
   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;
   logic             beat;
   logic             release_now;

   // In GRANT the picker is only consulted on release, where the pointer becomes sel+1.
   assign pick_ptr = (state_q == ST_GRANT) ? (sel_q + 1'b1) : ptr_q;

   rr_pick u_pick (
      .req (req),
      .ptr (pick_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign out_valid   = (state_q == ST_GRANT) && req[sel_q];
   assign beat        = out_valid && out_ready;
   assign release_now = (state_q == ST_GRANT) &&
                        (!req[sel_q] || (beat && (beat_cnt_q == LAST_BEAT)));

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sel_d      = sel_q;
      gnt_d      = gnt_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d    = ST_GRANT;
               sel_d      = pick_idx;
               gnt_d      = onehot(pick_idx);
               beat_cnt_d = '0;
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               ptr_d      = sel_q + 1'b1;
               beat_cnt_d = '0;
               if (pick_any) begin
                  sel_d = pick_idx;
                  gnt_d = onehot(pick_idx);
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end else if (beat) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         sel_q      <= '0;
         gnt_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         sel_q      <= sel_d;
         gnt_q      <= gnt_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign sel      = sel_q;
   assign gnt      = gnt_q;
   assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor checks each accepted beat.
module tb_mux16_rr_scheduler;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] cnt;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic        out_ready;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        out_valid;
   logic [7:0]  beat_cnt;

   int    checks;
   int    errors;
   beat_t exp_q[$];

   mux16_rr_scheduler #(.MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .out_ready (out_ready),
      .sel       (sel),
      .gnt       (gnt),
      .out_valid (out_valid),
      .beat_cnt  (beat_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_burst(input int s, input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.sel = 4'(s);
         b.cnt = 8'(k);
         exp_q.push_back(b);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_sel"}, 32'(sel), 32'd0);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_beat_cnt"}, 32'(beat_cnt), 32'd0);
   endtask

   task automatic do_reset();
      req       = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      check_idle_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every beat presented before an edge must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: sel=%0d beat_cnt=%0d with empty queue at %0t",
                     sel, beat_cnt, $time);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (sel !== e.sel || beat_cnt !== e.cnt || gnt !== (16'h1 << e.sel)) begin
               errors++;
               $display("FAIL beat: got sel=%0d gnt=0x%04h cnt=%0d expected sel=%0d gnt=0x%04h cnt=%0d at %0t",
                        sel, gnt, beat_cnt, e.sel, 16'h1 << e.sel, e.cnt, $time);
            end
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      do_reset();

      // 1: asynchronous reset in the middle of a grant
      req       = 16'h0020;
      out_ready = 1'b1;
      push_burst(5, 3);
      wait_edges(1);
      wait_edges(3);
      chk("s1_beat_cnt_before_reset", 32'(beat_cnt), 32'd3);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("s1_async");
      req       = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 2: single requester, forced release and regrant with no bubble
      req       = 16'h0020;
      out_ready = 1'b1;
      push_burst(5, 8);
      push_burst(5, 8);
      wait_edges(1);
      chk("s2_gnt", 32'(gnt), 32'h0020);
      chk("s2_sel", 32'(sel), 32'd5);
      chk("s2_valid", 32'(out_valid), 32'd1);
      wait_edges(7);
      chk("s2_cnt_last", 32'(beat_cnt), 32'd7);
      wait_edges(1);
      chk("s2_regrant_gnt", 32'(gnt), 32'h0020);
      chk("s2_regrant_cnt", 32'(beat_cnt), 32'd0);
      chk("s2_regrant_valid", 32'(out_valid), 32'd1);
      wait_edges(8);
      req = '0;
      wait_edges(1);
      chk("s2_idle_gnt", 32'(gnt), 32'd0);
      chk("s2_idle_sel_kept", 32'(sel), 32'd5);

      // 3: wrap-around between requesters 0 and 15
      do_reset();
      req       = 16'h8001;
      out_ready = 1'b1;
      push_burst(0, 8);
      push_burst(15, 8);
      push_burst(0, 8);
      wait_edges(1);
      chk("s3_first_sel", 32'(sel), 32'd0);
      wait_edges(8);
      chk("s3_wrap_sel", 32'(sel), 32'd15);
      wait_edges(16);
      chk("s3_back_sel", 32'(sel), 32'd15);
      req = '0;
      wait_edges(1);
      chk("s3_idle_gnt", 32'(gnt), 32'd0);

      // 4: back-pressure holds the grant, then exactly 8 beats
      do_reset();
      req       = 16'h0004;
      out_ready = 1'b0;
      wait_edges(1);
      wait_edges(20);
      chk("s4_stall_gnt", 32'(gnt), 32'h0004);
      chk("s4_stall_cnt", 32'(beat_cnt), 32'd0);
      chk("s4_stall_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      push_burst(2, 8);
      wait_edges(7);
      chk("s4_cnt7", 32'(beat_cnt), 32'd7);
      wait_edges(1);
      chk("s4_release_cnt", 32'(beat_cnt), 32'd0);
      chk("s4_regrant_gnt", 32'(gnt), 32'h0004);
      req       = '0;
      out_ready = 1'b0;
      wait_edges(1);
      chk("s4_idle_gnt", 32'(gnt), 32'd0);

      // 5: withdrawal moves the grant on at the next edge
      do_reset();
      req       = 16'h0018;
      out_ready = 1'b1;
      push_burst(3, 2);
      wait_edges(1);
      chk("s5_gnt3", 32'(gnt), 32'h0008);
      wait_edges(2);
      chk("s5_cnt2", 32'(beat_cnt), 32'd2);
      out_ready = 1'b0;
      req       = 16'h0010;
      wait_edges(1);
      chk("s5_gnt4", 32'(gnt), 32'h0010);
      chk("s5_sel4", 32'(sel), 32'd4);
      chk("s5_cnt0", 32'(beat_cnt), 32'd0);
      req = '0;
      wait_edges(1);
      chk("s5_idle_gnt", 32'(gnt), 32'd0);
      chk("s5_idle_valid", 32'(out_valid), 32'd0);

      // 6: fairness across all sixteen requesters
      do_reset();
      req       = 16'hFFFF;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) push_burst(i, 8);
      wait_edges(1);
      wait_edges(128);
      chk("s6_wrap_to_0", 32'(sel), 32'd0);
      req       = '0;
      out_ready = 1'b0;
      wait_edges(2);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
